// File: rtl/core_c1_lsu_biu_pkg.sv
// Shared definitions for the core_c1 data-side bus interface unit:
// FSM state encoding and load/store size codes.
package core_c1_defines;

  typedef enum logic [1:0] {
    LSU_BIU_IDLE = 2'b00,
    LSU_BIU_REQ  = 2'b01,
    LSU_BIU_WAIT = 2'b10,
    LSU_BIU_DONE = 2'b11
  } lsu_biu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 has no legal encoding, so it is always treated as misaligned.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_c1_lsu_biu_if.sv
// Core data bus: valid/ready request channel plus a response channel.
interface core_c1_lsu_biu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/core_c1_lsu_biu_align.sv
// Combinational lane logic: alignment check, store byte strobes and
// right-alignment of returned load data.
module core_c1_lsu_align
  import core_c1_defines::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic [1:0]  rd_offset,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_aligned
);

  always_comb begin
    misalign      = size_misaligned(size, addr_lo);
    wstrb         = 4'b0000;
    rdata_aligned = rdata >> {rd_offset, 3'b000};
    if (we) begin
      case (size)
        SIZE_B:  wstrb = 4'b0001 << addr_lo;
        SIZE_H:  wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        SIZE_W:  wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/core_c1_lsu_biu.sv
// Data-side bus interface unit: one load/store per instruction becomes a
// request/response on the data bus, stalling execute until it completes.
module core_c1_lsu_biu
  import core_c1_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [1:0]         mem_size,
  output logic               exu_pause,
  output logic [31:0]        lsu_load_data,
  output logic               lsu_misalign,
  output logic               lsu_bus_err,
  core_c1_lsu_biu_if.master  dbus
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_biu_state_e      state_q, state_d;
  logic                req_valid_q, req_valid_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic                req_we_q, req_we_d;
  logic [3:0]          req_wstrb_q, req_wstrb_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic [1:0]          offset_q, offset_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]         load_data_q, load_data_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;

  logic                acc_misalign;
  logic [3:0]          acc_wstrb;
  logic [31:0]         rdata_aligned;

  core_c1_lsu_align u_align (
    .addr_lo       (mem_addr[1:0]),
    .size          (mem_size),
    .we            (mem_we),
    .rd_offset     (offset_q),
    .rdata         (dbus.rsp_rdata),
    .misalign      (acc_misalign),
    .wstrb         (acc_wstrb),
    .rdata_aligned (rdata_aligned)
  );

  // Error flags are only ever set on entry to DONE, so they pulse for exactly that cycle.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    offset_d    = offset_q;
    to_cnt_d    = to_cnt_q;
    load_data_d = load_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      LSU_BIU_IDLE: begin
        if (mem_valid) begin
          if (acc_misalign) begin
            state_d    = LSU_BIU_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d     = LSU_BIU_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = {mem_addr[31:2], 2'b00};
            req_we_d    = mem_we;
            req_wstrb_d = acc_wstrb;
            req_wdata_d = mem_wdata;
            offset_d    = mem_addr[1:0];
          end
        end
      end
      LSU_BIU_REQ: begin
        if (dbus.req_ready) begin
          state_d     = LSU_BIU_WAIT;
          req_valid_d = 1'b0;
          to_cnt_d    = '0;
        end
      end
      LSU_BIU_WAIT: begin
        // A response on the expiry cycle wins over the timeout.
        if (dbus.rsp_valid) begin
          state_d   = LSU_BIU_DONE;
          bus_err_d = dbus.rsp_err;
          if (!req_we_q) begin
            load_data_d = dbus.rsp_err ? 32'h0 : rdata_aligned;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = LSU_BIU_DONE;
          bus_err_d   = 1'b1;
          load_data_d = 32'h0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      LSU_BIU_DONE: state_d = LSU_BIU_IDLE;
      default:      state_d = LSU_BIU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_BIU_IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
      req_we_q    <= 1'b0;
      req_wstrb_q <= 4'b0000;
      req_wdata_q <= 32'h0;
      offset_q    <= 2'b00;
      to_cnt_q    <= '0;
      load_data_q <= 32'h0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      offset_q    <= offset_d;
      to_cnt_q    <= to_cnt_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Pause depends on raw mem_valid only; the gated store enable downstream is not fed back.
  assign exu_pause      = mem_valid & (state_q != LSU_BIU_DONE);
  assign lsu_load_data  = load_data_q;
  assign lsu_misalign   = misalign_q;
  assign lsu_bus_err    = bus_err_q;
  assign dbus.req_valid = req_valid_q;
  assign dbus.req_addr  = req_addr_q;
  assign dbus.req_we    = req_we_q;
  assign dbus.req_wstrb = req_wstrb_q;
  assign dbus.req_wdata = req_wdata_q;

endmodule

// File: tb/tb_core_c1_lsu_biu.sv
// Randomized and directed bench for core_c1_lsu_biu, checked cycle by cycle
// against a transaction-level model of the expected bus and stall behaviour.
module tb_core_c1_lsu_biu;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        exu_pause;
  logic [31:0] lsu_load_data;
  logic        lsu_misalign;
  logic        lsu_bus_err;

  int n_checks;
  int n_pass;
  logic [31:0] exp_load;

  core_c1_lsu_biu_if dbus ();

  core_c1_lsu_biu #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_size      (mem_size),
    .exu_pause     (exu_pause),
    .lsu_load_data (lsu_load_data),
    .lsu_misalign  (lsu_misalign),
    .lsu_bus_err   (lsu_bus_err),
    .dbus          (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference rules for legality, byte lanes and load alignment.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] a);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (a % 2) != 0;
    if (size == 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_strobe(input logic we, input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    int nbytes;
    s = 4'b0000;
    if (!we) return s;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) s[int'(a) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] right_align(input logic [31:0] rdata, input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i + int'(a) < 4; i++) r[8*i +: 8] = rdata[8*(i + int'(a)) +: 8];
    return r;
  endfunction

  // One full access: drives the execute side and plays the bus slave with the given
  // ready/response delays, checking every cycle until the BIU is back in IDLE.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic [31:0] rdata, input int rd,
                               input int rsp_dly, input logic err, input logic no_rsp,
                               input int flush_at);
    logic ill;
    logic mv;
    logic exp_rv;
    int n_done;
    logic [3:0] strb;

    ill    = is_illegal(size, addr[1:0]);
    n_done = ill ? 1 : (no_rsp ? 2 + rd + TO : 3 + rd + rsp_dly);
    strb   = exp_strobe(we, size, addr[1:0]);
    if (!ill) begin
      if (no_rsp) exp_load = 32'h0;
      else if (!we) exp_load = err ? 32'h0 : right_align(rdata, addr[1:0]);
    end

    mv        = 1'b1;
    mem_valid = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_size  = size;
    #1;
    checkOutput("pause_first", {31'h0, exu_pause}, 32'h1);

    for (int n = 1; n <= n_done + 1; n++) begin
      @(negedge clk);
      exp_rv = !ill && (n <= 1 + rd);
      checkOutput("pause", {31'h0, exu_pause}, {31'h0, mv && (n != n_done)});
      checkOutput("req_valid", {31'h0, dbus.req_valid}, {31'h0, exp_rv});
      if (exp_rv) begin
        checkOutput("req_addr", dbus.req_addr, {addr[31:2], 2'b00});
        checkOutput("req_we", {31'h0, dbus.req_we}, {31'h0, we});
        checkOutput("req_wstrb", {28'h0, dbus.req_wstrb}, {28'h0, strb});
        if (we) checkOutput("req_wdata", dbus.req_wdata, wdata);
      end
      checkOutput("misalign", {31'h0, lsu_misalign}, {31'h0, (n == n_done) && ill});
      checkOutput("bus_err", {31'h0, lsu_bus_err}, {31'h0, (n == n_done) && !ill && (err || no_rsp)});
      if (n == n_done) checkOutput("load_data", lsu_load_data, exp_load);

      dbus.req_ready = !ill && (n == 1 + rd);
      dbus.rsp_valid = !ill && !no_rsp && (n == 2 + rd + rsp_dly);
      dbus.rsp_rdata = dbus.rsp_valid ? rdata : $urandom;
      dbus.rsp_err   = dbus.rsp_valid ? err : 1'($urandom);
      if (n == n_done || n == flush_at) mv = 1'b0;
      mem_valid = mv;
      if (!mv) begin
        mem_we    = 1'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_size  = 2'($urandom);
      end
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    exp_load       = 32'h0;
    rst            = 1'b1;
    mem_valid      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_size       = 2'b00;
    dbus.req_ready = 1'b0;
    dbus.rsp_valid = 1'b0;
    dbus.rsp_rdata = 32'h0;
    dbus.rsp_err   = 1'b0;

    #1;
    checkOutput("rst_req_valid", {31'h0, dbus.req_valid}, 32'h0);
    checkOutput("rst_req_addr", dbus.req_addr, 32'h0);
    checkOutput("rst_wstrb", {28'h0, dbus.req_wstrb}, 32'h0);
    checkOutput("rst_load_data", lsu_load_data, 32'h0);
    checkOutput("rst_pause", {31'h0, exu_pause}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 2'b10, 32'h0, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_2003, 32'h0, 2'b00, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_2002, 32'h0, 2'b01, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b1, 32'h0000_3001, 32'h1234_1234, 2'b01, 32'h0, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b1, 32'h0000_3002, 32'h1111_2222, 2'b10, 32'h0, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_3000, 32'h0, 2'b11, 32'h0, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b1, 32'h0000_4002, 32'h5A5A_5A5A, 2'b00, 32'h0, 5, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_5001, 32'h0, 2'b00, 32'hCAFE_F00D, 1, 2, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_5000, 32'h0, 2'b10, 32'h1234_5678, 0, 0, 1'b0, 1'b1, -1);
    applyStimulus(1'b0, 32'h0000_5004, 32'h0, 2'b10, 32'h1234_5678, 0, 1, 1'b1, 1'b0, -1);
    applyStimulus(1'b0, 32'h0000_5008, 32'h0, 2'b10, 32'h0BAD_C0DE, 0, TO - 1, 1'b0, 1'b0, -1);
    applyStimulus(1'b1, 32'h0000_500C, 32'h7777_8888, 2'b10, 32'h0, 2, 1, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 32'h0000_2003, 32'h0, 2'b00, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, -1);

    $display("[TB] reset during WAIT");
    mem_valid = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_6000;
    mem_wdata = 32'hFFFF_0000;
    mem_size  = 2'b10;
    @(negedge clk);
    dbus.req_ready = 1'b1;
    @(negedge clk);
    dbus.req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_req_valid", {31'h0, dbus.req_valid}, 32'h0);
    checkOutput("arst_req_addr", dbus.req_addr, 32'h0);
    checkOutput("arst_req_wdata", dbus.req_wdata, 32'h0);
    checkOutput("arst_load_data", lsu_load_data, 32'h0);
    checkOutput("arst_bus_err", {31'h0, lsu_bus_err}, 32'h0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    exp_load = 32'h0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h0000_7002, 32'h0, 2'b01, 32'hA1B2_C3D4, 0, 0, 1'b0, 1'b0, -1);

    $display("[TB] randomized accesses");
    for (int t = 0; t < 80; t++) begin
      applyStimulus(1'($urandom), $urandom, $urandom, 2'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
